barrido_display: RTL and testbench

//  Time-multiplexed driver for the board's 8-digit common-anode 7-segment display.

---
 rtl/barrido_display_pkg.sv | 41 ++++
 rtl/barrido_display_seg_decodificador.sv | 15 +
 rtl/barrido_display.sv | 140 ++++++++++++++
 tb/tb_barrido_display.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/barrido_display_pkg.sv
// Shared constants for the 8-digit common-anode 7-segment scanner.
//
// Contents:
//   N_DIGITS   number of multiplexed digits
//   SEG_OFF    all segments dark (active-low)
//   AN_OFF     all anodes off (active-low)
//   SEG_GLYPH  hex glyph table, active-low, bit order g f e d c b a
//   dim_end    lit-window end for a given brightness level (elaboration-time use only)
package barrido_display_pkg;

  localparam int N_DIGITS = 8;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // Standard hex glyphs; a 0 bit lights the segment.
  localparam logic [6:0] SEG_GLYPH [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

  // Exclusive end of the lit window for brightness level 0..7 (7 = full slot).
  function automatic int dim_end(input int tick_div, input int blank, input int level);
    return blank + (((tick_div - blank) * (level + 1)) >>> 3);
  endfunction

endpackage

// File: rtl/barrido_display_seg_decodificador.sv
// seg_decodificador: combinational nibble-to-segment lookup.
//
// Ports:
//   nibble  in  4  hex digit value
//   seg     out 7  active-low segments, g f e d c b a
module seg_decodificador
  import barrido_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_GLYPH[nibble];

endmodule

// File: rtl/barrido_display.sv
// barrido_display: time-multiplexed driver for an 8-digit common-anode
// 7-segment display.
//
// A prescaler divides each digit slot into TICK_DIV clocks. The first
// BLANK_CYCLES clocks of every slot keep all anodes off so the previous
// digit's segments never ghost onto the next one. The display word and
// decimal-point mask are latched only when the scan wraps from digit 7 to
// digit 0, so a frame never mixes nibbles from two different words.
//
// Optional feature (macro BARRIDO_DIM_EN): adds a 3-bit `brillo` input that
// shortens the lit window for brightness control. It is latched together
// with the word at frame boundaries.
//
// Ports:
//   clk          in   1   system clock
//   rst_n        in   1   asynchronous active-low reset
//   dato         in   32  nibble word, digit i = dato[4i+3:4i], digit 7 leftmost
//   dp_mask      in   8   decimal point request per digit, 1 = lit
//   brillo       in   3   brightness 0 (dimmest) .. 7 (full); BARRIDO_DIM_EN only
//   an           out  8   anodes, active-low, an[i] drives digit i
//   seg          out  7   segments, active-low, g f e d c b a
//   dp           out  1   decimal point, active-low
//   frame_start  out  1   one-clock pulse when the digit 0 slot begins
module barrido_display
  import barrido_display_pkg::*;
#(
  parameter int TICK_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] dato,
  input  logic [7:0]  dp_mask,
`ifdef BARRIDO_DIM_EN
  input  logic [2:0]  brillo,
`endif
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [31:0]   frame_reg;
  logic [7:0]    dp_mask_reg;

  logic          tick;
  logic          load;
  logic          lit;
  logic [3:0]    nibble;
  logic [6:0]    glyph;

  assign tick = (cnt == CW'(TICK_DIV - 1));
  // The last slot of a frame is ending: the next slot is digit 0 of a new frame.
  assign load = tick && (idx == 3'(N_DIGITS - 1));

`ifdef BARRIDO_DIM_EN
  localparam int TW = $clog2(TICK_DIV + 1);

  // Window ends for every brightness level are elaboration-time constants,
  // so choosing one per frame is a small mux rather than a multiplier.
  logic [TW-1:0] dim_tab [8];
  logic [TW-1:0] lit_end;

  for (genvar g = 0; g < 8; g++) begin : g_dim_tab
    assign dim_tab[g] = TW'(dim_end(TICK_DIV, BLANK_CYCLES, g));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lit_end <= TW'(TICK_DIV);   // first frame after reset at full brightness
    end else if (load) begin
      lit_end <= dim_tab[brillo];
    end
  end

  assign lit = (cnt >= CW'(BLANK_CYCLES)) && (TW'(cnt) < lit_end);
`else
  assign lit = (cnt >= CW'(BLANK_CYCLES));
`endif

  // Prescaler and digit index.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (tick) begin
      cnt <= '0;
      idx <= idx + 3'd1;   // 7 wraps to 0 naturally
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Frame latch: word and dp mask change only between frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_reg   <= '0;
      dp_mask_reg <= '0;
    end else if (load) begin
      frame_reg   <= dato;
      dp_mask_reg <= dp_mask;
    end
  end

  assign nibble = frame_reg[{idx, 2'b00} +: 4];

  seg_decodificador u_seg_decodificador (
    .nibble (nibble),
    .seg    (glyph)
  );

  // Registered outputs, one clock behind cnt/idx. Outside the lit window all
  // anodes are off, so at most one anode is ever low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an          <= AN_OFF;
      seg         <= SEG_OFF;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= load;
      if (lit) begin
        an  <= ~(8'b1 << idx);
        seg <= glyph;
        dp  <= ~dp_mask_reg[idx];
      end else begin
        an  <= AN_OFF;
        seg <= SEG_OFF;
        dp  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_barrido_display.sv
// Self-checking bench for barrido_display with TICK_DIV=8, BLANK_CYCLES=2.
// A cycle-count reference model predicts every output on every clock from
// the edge count since reset and the words captured at frame boundaries.
// Honours BARRIDO_DIM_EN when the build defines it.
module tb_barrido_display;

  localparam int T     = 8;
  localparam int B     = 2;
  localparam int FRAME = 8 * T;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] dato;
  logic [7:0]  dp_mask;
  logic [2:0]  brillo;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  barrido_display #(.TICK_DIV(T), .BLANK_CYCLES(B)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dato        (dato),
    .dp_mask     (dp_mask),
`ifdef BARRIDO_DIM_EN
    .brillo      (brillo),
`endif
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Active-high hex glyphs (a = bit 0); the display wants the complement.
  logic [6:0] glyph_hi [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic int window_end(input logic [2:0] b);
`ifdef BARRIDO_DIM_EN
    return B + (((T - B) * (int'(b) + 1)) / 8);
`else
    return T;
`endif
  endfunction

  // Reference model state: edges since reset, and the current/previous frame settings.
  int          e;
  logic [31:0] cur_word, prev_word;
  logic [7:0]  cur_dp, prev_dp;
  int          cur_end, prev_end;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e         <= 0;
      cur_word  <= '0;  prev_word <= '0;
      cur_dp    <= '0;  prev_dp   <= '0;
      cur_end   <= T;   prev_end  <= T;
    end else begin
      e <= e + 1;
      if ((e + 1) % FRAME == 0) begin
        prev_word <= cur_word;  cur_word <= dato;
        prev_dp   <= cur_dp;    cur_dp   <= dp_mask;
        prev_end  <= cur_end;   cur_end  <= window_end(brillo);
      end
    end
  end

  // Per-cycle comparison on the falling edge.
  int          k, c, d;
  logic        lit;
  logic [31:0] w;
  logic [7:0]  m;
  int          we;
  logic [7:0]  x_an;
  logic [6:0]  x_seg;
  logic        x_dp;
  logic        x_fs;

  always @(negedge clk) begin
    if (!rst_n || e == 0) begin
      x_an = 8'hFF; x_seg = 7'h7F; x_dp = 1'b1; x_fs = 1'b0;
    end else begin
      k = e - 1;
      c = k % T;
      d = (k / T) % 8;
      // The output at edge e reflects the state before it, which may still
      // belong to the previous frame when the load happened on this edge.
      if (k / FRAME == e / FRAME) begin
        w = cur_word; m = cur_dp; we = cur_end;
      end else begin
        w = prev_word; m = prev_dp; we = prev_end;
      end
      lit   = (c >= B) && (c < we);
      x_an  = lit ? ~(8'b1 << d) : 8'hFF;
      x_seg = lit ? ~glyph_hi[(w >> (4 * d)) & 32'hF] : 7'h7F;
      x_dp  = lit ? ~m[d] : 1'b1;
      x_fs  = (e % FRAME == 0);
    end
    check("an", 32'(an), 32'(x_an));
    check("seg", 32'(seg), 32'(x_seg));
    check("dp", 32'(dp), 32'(x_dp));
    check("frame_start", 32'(frame_start), 32'(x_fs));
    check("an_onehot", 32'($countones(~an) <= 1), 32'd1);
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n   = 1'b0;
    dato    = '0;
    dp_mask = '0;
    brillo  = 3'd7;
    run(3);
    rst_n = 1'b1;

    // Word held for two full frames with decimal points on digits 0 and 7.
    dato    = 32'h1234_5678;
    dp_mask = 8'h81;
    run(3 * FRAME);

    // Change the word while digit 3 is being shown.
    for (int i = 0; i < FRAME && (e % FRAME) != 3 * T + 3; i++) @(negedge clk);
    dato = 32'hEEEE_EEEE;
    run(2 * FRAME);

    // Brightness levels (only effective when dimming is built in).
    brillo = 3'd3;
    run(2 * FRAME);
    brillo = 3'd7;
    run(2 * FRAME);

    // Random words, masks and brightness changing at random moments.
    for (int i = 0; i < 12; i++) begin
      run($urandom_range(1, 150));
      dato    = $urandom;
      dp_mask = 8'($urandom);
      brillo  = 3'($urandom);
    end
    run(2 * FRAME);

    // Asynchronous reset mid-slot: outputs must drop at once.
    run(37);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_an", 32'(an), 32'hFF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp", 32'(dp), 32'd1);
    check("rst_fs", 32'(frame_start), 32'd0);
    run(2);
    rst_n = 1'b1;
    dato    = $urandom;
    dp_mask = 8'($urandom);
    run(3 * FRAME);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
